// File: rtl/fixedpoint_accum.sv
// Accumulates N signed fixed-point products in a guard-bit accumulator, then
// rounds half-up and saturates the block sum onto a narrower Q(WIO.WFO) output.
module fixedpoint_accum #(
  parameter int WII = 16,
  parameter int WFI = 16,
  parameter int WIO = 8,
  parameter int WFO = 8,
  parameter int N   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WII+WFI-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   out_data,
  output logic                 out_sat
);

  localparam int IN_W  = WII + WFI;
  localparam int OUT_W = WIO + WFO;
  localparam int CNT_W = $clog2(N);
  localparam int ACC_W = IN_W + CNT_W;
  localparam int S     = WFI - WFO;

  localparam logic ST_ACC = 1'b0;
  localparam logic ST_OUT = 1'b1;

  // One extra bit above the accumulator so the rounding offset can never wrap.
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (S - 1);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  localparam logic [OUT_W-1:0] MAX_CODE = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_CODE = {1'b1, {(OUT_W - 1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    state_q, state_d;
  logic [OUT_W-1:0]        outData_q, outData_d;
  logic                    outSat_q, outSat_d;

  logic signed [ACC_W:0]   sumExt;
  logic signed [ACC_W:0]   rounded;
  logic signed [ACC_W:0]   shifted;
  logic                    accept;
  logic                    lastSample;

  assign in_ready   = (state_q == ST_ACC);
  assign out_valid  = (state_q == ST_OUT);
  assign out_data   = outData_q;
  assign out_sat    = outSat_q;

  assign accept     = in_valid && in_ready;
  assign lastSample = (cnt_q == CNT_W'(N - 1));

  assign sumExt  = $signed({acc_q[ACC_W-1], acc_q})
                 + $signed({{(CNT_W + 1){in_data[IN_W-1]}}, in_data});
  assign rounded = sumExt + HALF;
  assign shifted = rounded >>> S;

  // clr outranks everything: it neither accepts input nor completes an output handshake.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    outData_d = outData_q;
    outSat_d  = outSat_q;
    if (clr) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = ST_ACC;
    end else begin
      if (state_q == ST_OUT && out_ready) begin
        state_d = ST_ACC;
      end
      if (accept) begin
        if (lastSample) begin
          if (shifted > MAXV) begin
            outData_d = MAX_CODE;
            outSat_d  = 1'b1;
          end else if (shifted < MINV) begin
            outData_d = MIN_CODE;
            outSat_d  = 1'b1;
          end else begin
            outData_d = shifted[OUT_W-1:0];
            outSat_d  = 1'b0;
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_OUT;
        end else begin
          acc_d = sumExt[ACC_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      state_q   <= ST_ACC;
      outData_q <= '0;
      outSat_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      outData_q <= outData_d;
      outSat_q  <= outSat_d;
    end
  end

endmodule

// File: tb/tb_fixedpoint_accum.sv
// Self-checking bench for fixedpoint_accum: directed blocks with known results
// plus a randomized phase compared every cycle against an arithmetic model.
module tb_fixedpoint_accum;

  localparam int WII   = 16;
  localparam int WFI   = 16;
  localparam int WIO   = 8;
  localparam int WFO   = 8;
  localparam int N     = 8;
  localparam int IN_W  = WII + WFI;
  localparam int OUT_W = WIO + WFO;
  localparam int S     = WFI - WFO;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;

  int checkCount = 0;
  int errorCount = 0;

  // Reference state: the running block sum as a plain integer.
  longint            mSum;
  int                mCnt;
  bit                mValid;
  logic [OUT_W-1:0]  mData;
  bit                mSat;

  fixedpoint_accum #(.WII(WII), .WFI(WFI), .WIO(WIO), .WFO(WFO), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Round half-up, then clip to the signed output range.
  task automatic finishBlock();
    real    scaled;
    longint r;
    longint maxV;
    maxV   = (longint'(1) <<< (OUT_W - 1)) - 1;
    scaled = $floor((real'(mSum) + real'(longint'(1) <<< (S - 1))) / real'(longint'(1) <<< S));
    r      = longint'(scaled);
    if (r > maxV) begin
      mData = {1'b0, {(OUT_W - 1){1'b1}}};
      mSat  = 1'b1;
    end else if (r < -maxV - 1) begin
      mData = {1'b1, {(OUT_W - 1){1'b0}}};
      mSat  = 1'b1;
    end else begin
      mData = r[OUT_W-1:0];
      mSat  = 1'b0;
    end
    mSum   = 0;
    mCnt   = 0;
    mValid = 1'b1;
  endtask

  always @(negedge rst_n) begin
    mSum   = 0;
    mCnt   = 0;
    mValid = 1'b0;
    mData  = '0;
    mSat   = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (clr) begin
        mSum   = 0;
        mCnt   = 0;
        mValid = 1'b0;
      end else begin
        bit canTake;
        canTake = !mValid;
        if (mValid && out_ready) mValid = 1'b0;
        if (in_valid && canTake) begin
          mSum = mSum + longint'($signed(in_data));
          mCnt++;
          if (mCnt == N) finishBlock();
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("monValid", out_valid, mValid);
    checkOutput("monReady", in_ready, !mValid);
    checkOutput("monData", out_data, mData);
    checkOutput("monSat", out_sat, mSat);
  end

  task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d, input logic ordy, input logic c);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
  endtask

  task automatic sendSample(input logic [IN_W-1:0] d);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) checkOutput("sendTimeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic runBlock(input string tag, input logic [IN_W-1:0] first, input logic [IN_W-1:0] rest,
                          input logic [OUT_W-1:0] expData, input logic expSat);
    out_ready = 1'b1;
    sendSample(first);
    for (int i = 1; i < N; i++) sendSample(rest);
    @(negedge clk);
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_data"}, out_data, expData);
    checkOutput({tag, "_sat"}, out_sat, expSat);
    @(negedge clk);
    checkOutput({tag, "_drained"}, out_valid, 0);
    checkOutput({tag, "_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    checkOutput("rstReady", in_ready, 1);
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstData", out_data, 0);
    checkOutput("rstSat", out_sat, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    runBlock("basic", 32'h0001_8000, 32'h0001_8000, 16'h0C00, 1'b0);
    runBlock("satPos", 32'h0014_0000, 32'h0014_0000, 16'h7FFF, 1'b1);
    runBlock("satNeg", 32'hFFEC_0000, 32'hFFEC_0000, 16'h8000, 1'b1);
    runBlock("rndUp", 32'h0000_0080, 32'h0, 16'h0001, 1'b0);
    runBlock("rndDown", 32'h0000_007F, 32'h0, 16'h0000, 1'b0);
    runBlock("rndNegHalf", 32'hFFFF_FF80, 32'h0, 16'h0000, 1'b0);
    runBlock("rndNeg", 32'hFFFF_FF7F, 32'h0, 16'hFFFF, 1'b0);

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) sendSample(32'h0001_0000);
    in_valid = 1'b1;
    in_data  = 32'h0003_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpValid", out_valid, 1);
      checkOutput("bpData", out_data, 16'h0800);
      checkOutput("bpReady", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpReleased", out_valid, 0);
    checkOutput("bpReadyBack", in_ready, 1);

    // Abort a partial block.
    for (int i = 0; i < 3; i++) sendSample(32'h0005_0000);
    applyStimulus(1'b1, 32'h0005_0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    runBlock("abortPartial", 32'h0001_0000, 32'h0001_0000, 16'h0800, 1'b0);

    // Abort a pending output.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) sendSample(32'h0002_0000);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("abortOutValid", out_valid, 0);
    checkOutput("abortOutData", out_data, 16'h1000);

    // Asynchronous reset mid-block, between clock edges.
    for (int i = 0; i < 4; i++) sendSample(32'h0001_0000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", out_valid, 0);
    checkOutput("midRstData", out_data, 0);
    checkOutput("midRstSat", out_sat, 0);
    checkOutput("midRstReady", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    runBlock("afterRst", 32'h0000_8000, 32'h0000_8000, 16'h0400, 1'b0);

    // Randomized traffic, checked cycle by cycle by the model monitor.
    for (int i = 0; i < 3000; i++) begin
      logic [IN_W-1:0] d;
      case ($urandom_range(0, 2))
        0:       d = IN_W'($urandom);
        1:       d = IN_W'(int'($urandom_range(0, 2 * 1500000)) - 1500000);
        default: d = IN_W'(int'($urandom_range(0, 2 * 40000)) - 40000);
      endcase
      applyStimulus(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 63) == 0));
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
